hazard_flush_ctrl: RTL and testbench

- Pipeline hazard and flush sequencer for the 5-stage RV32I core.
- Produces stage write-enables, and the flush strobes that drive the IF/ID NOP-insertion mux (ADD x0,x0,x0) and the ID/EX bubble.
- Arbitrates between three events, highest priority first:
  1. data-memory wait (Mem_Busy),
  2. taken branch/jump resolved in EX,
  3. load-use hazard.
- Keeps stall and flush event counters for performance debug.

---
 rtl/hazard_flush_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_flush_ctrl
// Purpose : Hazard and flush sequencer for a 5-stage RV32I pipeline.
//           Three events are arbitrated in fixed priority order:
//             1. data-memory wait (whole-pipe freeze),
//             2. taken branch/jump resolved in EX (IF/ID + ID/EX flush),
//             3. load-use hazard (one-cycle stall with an ID/EX bubble).
//           Registered counters of load-use stalls and serviced branches are
//           kept for performance debug.
// Ports   :
//   Clk, Rst_n          - clock, synchronous active-low reset
//   Is_Branch_Taken     - taken branch/jump resolved in EX this cycle
//   Mem_Busy            - data memory not ready
//   EX_Mem_Read, EX_Rd  - load in EX and its destination register
//   ID_Rs1/2, *_Used    - source registers of the instruction in ID
//   PC_Write            - PC update enable
//   IF_ID_Write         - IF/ID register enable
//   IF_ID_Flush         - select NOP into IF/ID
//   ID_EX_Flush         - insert bubble into ID/EX
//   Pipe_Freeze         - hold ID/EX, EX/MEM, MEM/WB
//   Stall_Count         - load-use stall cycles (wraps)
//   Flush_Count         - taken branches serviced (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module hazard_flush_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Is_Branch_Taken,
  input  logic             Mem_Busy,
  input  logic             EX_Mem_Read,
  input  logic [4:0]       EX_Rd,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_Rs1_Used,
  input  logic             ID_Rs2_Used,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             Pipe_Freeze,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Remaining flush cycles loaded after the branch cycle itself.
  localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic hz;
  logic take_branch;
  logic take_stall;
  logic freeze;

  // Load-use hazard: only the listed inputs feed this term, so no loop
  // can form through the stage enables.
  assign hz = EX_Mem_Read && (EX_Rd != 5'd0) &&
              ((ID_Rs1_Used && (ID_Rs1 == EX_Rd)) ||
               (ID_Rs2_Used && (ID_Rs2 == EX_Rd)));

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    pend_flush_d  = pend_flush_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    take_branch   = 1'b0;
    take_stall    = 1'b0;
    freeze        = 1'b0;

    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    Pipe_Freeze   = 1'b0;

    case (state_q)
      RUN: begin
        if (Mem_Busy) begin
          freeze       = 1'b1;
          pend_flush_d = Is_Branch_Taken;
          state_d      = MEM_WAIT;
        end else if (Is_Branch_Taken) begin
          take_branch = 1'b1;
        end else if (hz) begin
          take_stall = 1'b1;
        end
      end

      FLUSH: begin
        // A branch seen here is ignored: EX only holds a bubble.
        if (Mem_Busy) begin
          freeze = 1'b1;
        end else begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
          if (fcnt_q <= 4'd1) begin
            fcnt_d  = 4'd0;
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
      end

      MEM_WAIT: begin
        if (Mem_Busy) begin
          freeze       = 1'b1;
          // The frozen EX instruction may resolve taken while we wait.
          pend_flush_d = pend_flush_q | Is_Branch_Taken;
        end else begin
          pend_flush_d = 1'b0;
          state_d      = RUN;
          if (pend_flush_q || Is_Branch_Taken) begin
            take_branch = 1'b1;
          end else if (hz) begin
            take_stall = 1'b1;
          end
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    if (take_branch) begin
      IF_ID_Flush   = 1'b1;
      ID_EX_Flush   = 1'b1;
      flush_count_d = flush_count_q + CNT_W'(1);
      if (FLUSH_CYCLES > 1) begin
        fcnt_d  = FCNT_INIT;
        state_d = FLUSH;
      end
    end

    if (take_stall) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Flush   = 1'b1;
      stall_count_d = stall_count_q + CNT_W'(1);
    end

    if (freeze) begin
      Pipe_Freeze = 1'b1;
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
    end

    // While reset is held the front end is forced to inject NOPs/bubbles.
    if (!Rst_n) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      Pipe_Freeze = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q       <= RUN;
      fcnt_q        <= 4'd0;
      pend_flush_q  <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      pend_flush_q  <= pend_flush_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign Stall_Count = stall_count_q;
  assign Flush_Count = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_flush_ctrl
// Purpose : Self-checking bench for hazard_flush_ctrl (FLUSH_CYCLES=3,
//           CNT_W=4). A behavioural model tracks the number of flush cycles
//           still owed, whether the pipe is waiting on memory, and any
//           branch remembered during that wait.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_flush_ctrl;

  localparam int FC   = 3;
  localparam int CW   = 4;
  localparam int CMSK = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Is_Branch_Taken, Mem_Busy, EX_Mem_Read;
  logic [4:0]    EX_Rd, ID_Rs1, ID_Rs2;
  logic          ID_Rs1_Used, ID_Rs2_Used;
  logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze;
  logic [CW-1:0] Stall_Count, Flush_Count;

  hazard_flush_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Is_Branch_Taken(Is_Branch_Taken), .Mem_Busy(Mem_Busy),
    .EX_Mem_Read(EX_Mem_Read), .EX_Rd(EX_Rd),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2),
    .ID_Rs1_Used(ID_Rs1_Used), .ID_Rs2_Used(ID_Rs2_Used),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .Pipe_Freeze(Pipe_Freeze),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_flush_left = 0;  // flush cycles still owed after the branch cycle
  bit m_waiting    = 0;  // memory wait in progress
  bit m_pend       = 0;  // branch remembered during the wait
  int m_stalls     = 0;
  int m_flushes    = 0;
  // Next-state of the model, applied at the clock edge
  int n_flush_left, n_stalls, n_flushes;
  bit n_waiting, n_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    Is_Branch_Taken = 0; Mem_Busy = 0; EX_Mem_Read = 0;
    EX_Rd = 0; ID_Rs1 = 0; ID_Rs2 = 0; ID_Rs1_Used = 0; ID_Rs2_Used = 0;
  endtask

  task automatic set_loaduse(input logic [4:0] rd);
    EX_Mem_Read = 1; EX_Rd = rd; ID_Rs2 = 5'd5; ID_Rs2_Used = 1;
  endtask

  // Expected outputs for the current cycle, plus model next-state.
  task automatic eval_and_check();
    bit hz, br;
    bit e_pc, e_ifw, e_iff, e_idf, e_frz;
    hz = EX_Mem_Read && (EX_Rd != 0) &&
         ((ID_Rs1_Used && ID_Rs1 == EX_Rd) || (ID_Rs2_Used && ID_Rs2 == EX_Rd));
    e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_frz = 0;
    n_flush_left = m_flush_left; n_waiting = m_waiting; n_pend = m_pend;
    n_stalls = m_stalls; n_flushes = m_flushes;
    if (!Rst_n) begin
      e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
      n_flush_left = 0; n_waiting = 0; n_pend = 0; n_stalls = 0; n_flushes = 0;
    end else if (m_flush_left > 0) begin
      if (Mem_Busy) begin
        e_frz = 1; e_pc = 0; e_ifw = 0;
      end else begin
        e_iff = 1; e_idf = 1; n_flush_left = m_flush_left - 1;
      end
    end else if (Mem_Busy) begin
      e_frz = 1; e_pc = 0; e_ifw = 0;
      n_pend = (m_waiting ? m_pend : 1'b0) | Is_Branch_Taken;
      n_waiting = 1;
    end else begin
      br = Is_Branch_Taken | (m_waiting & m_pend);
      n_waiting = 0; n_pend = 0;
      if (br) begin
        e_iff = 1; e_idf = 1; n_flushes = m_flushes + 1; n_flush_left = FC - 1;
      end else if (hz) begin
        e_pc = 0; e_ifw = 0; e_idf = 1; n_stalls = m_stalls + 1;
      end
    end
    chk("pc_write",    32'(PC_Write),    32'(e_pc));
    chk("if_id_write", 32'(IF_ID_Write), 32'(e_ifw));
    chk("if_id_flush", 32'(IF_ID_Flush), 32'(e_iff));
    chk("id_ex_flush", 32'(ID_EX_Flush), 32'(e_idf));
    chk("pipe_freeze", 32'(Pipe_Freeze), 32'(e_frz));
    chk("stall_count", 32'(Stall_Count), 32'(m_stalls & CMSK));
    chk("flush_count", 32'(Flush_Count), 32'(m_flushes & CMSK));
  endtask

  // One clock cycle: inputs already applied just after the previous edge.
  task automatic step();
    #3;
    eval_and_check();
    @(posedge Clk);
    m_flush_left = n_flush_left; m_waiting = n_waiting; m_pend = n_pend;
    m_stalls = n_stalls; m_flushes = n_flushes;
    #1;
  endtask

  initial begin
    int base;
    set_idle();
    Rst_n = 0;
    @(posedge Clk); #1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      chk("rst_pc_write", 32'(PC_Write), 32'd0);
      chk("rst_if_flush", 32'(IF_ID_Flush), 32'd1);
      step();
    end
    Rst_n = 1;
    #1;
    chk("post_rst_stall", 32'(Stall_Count), 32'd0);
    chk("post_rst_flush", 32'(Flush_Count), 32'd0);
    chk("post_rst_if_flush", 32'(IF_ID_Flush), 32'd0);
    step();

    // Load-use stall, then the same with x0 as destination
    set_loaduse(5'd5);
    #1;
    chk("lu_pc_write", 32'(PC_Write), 32'd0);
    chk("lu_ifid_write", 32'(IF_ID_Write), 32'd0);
    chk("lu_idex_flush", 32'(ID_EX_Flush), 32'd1);
    step();
    set_idle();
    chk("lu_stall_cnt", 32'(Stall_Count), 32'd1);
    step();
    set_loaduse(5'd0); ID_Rs2 = 5'd0;
    #1;
    chk("lu_x0_pc_write", 32'(PC_Write), 32'd1);
    step();
    set_idle();
    chk("lu_x0_stall_cnt", 32'(Stall_Count), 32'd1);

    // Branch pulse with a simultaneous hazard: flush for 3 cycles only
    Is_Branch_Taken = 1; set_loaduse(5'd5);
    #1;
    chk("br_t0_flush", 32'(IF_ID_Flush), 32'd1);
    chk("br_t0_pc_write", 32'(PC_Write), 32'd1);
    step();
    set_idle();
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("br_t%0d_flush", i), 32'(IF_ID_Flush), (i < 3) ? 32'd1 : 32'd0);
      step();
    end
    chk("br_flush_cnt", 32'(Flush_Count), 32'd1);
    chk("br_stall_cnt", 32'(Stall_Count), 32'd1);

    // Memory wait for four cycles with a branch in the first
    base = m_flushes;
    Mem_Busy = 1; Is_Branch_Taken = 1;
    step();
    Is_Branch_Taken = 0;
    for (int i = 0; i < 3; i++) begin
      chk("mw_freeze", 32'(Pipe_Freeze), 32'd1);
      chk("mw_noflush", 32'(IF_ID_Flush), 32'd0);
      step();
    end
    Mem_Busy = 0;
    #1;
    chk("mw_release_flush", 32'(IF_ID_Flush), 32'd1);
    chk("mw_release_freeze", 32'(Pipe_Freeze), 32'd0);
    step();
    chk("mw_flush_cnt", 32'(Flush_Count), 32'((base + 1) & CMSK));
    step(); step(); step();

    // Counter wrap: 16 stalls from a fresh reset
    Rst_n = 0; step(); Rst_n = 1;
    set_loaduse(5'd5);
    for (int i = 0; i < 16; i++) step();
    set_idle();
    chk("wrap_stall_cnt", 32'(Stall_Count), 32'd0);
    step();

    // Reset in the middle of a flush sequence
    Is_Branch_Taken = 1; step();
    Is_Branch_Taken = 0; Rst_n = 0; step();
    Rst_n = 1;
    #1;
    chk("midflush_rst_flush", 32'(IF_ID_Flush), 32'd0);
    step(); step();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      Rst_n           = ($urandom_range(0, 99) != 0);
      Mem_Busy        = ($urandom_range(0, 3) == 0);
      Is_Branch_Taken = ($urandom_range(0, 4) == 0);
      EX_Mem_Read     = $urandom_range(0, 1);
      EX_Rd           = 5'($urandom_range(0, 3));
      ID_Rs1          = 5'($urandom_range(0, 3));
      ID_Rs2          = 5'($urandom_range(0, 3));
      ID_Rs1_Used     = $urandom_range(0, 1);
      ID_Rs2_Used     = $urandom_range(0, 1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
